// File: rtl/calc_btn_encoder.sv
//==============================================================================
// Module   : calc_btn_encoder
// Brief    : Encodes a 4-bit ALU opcode into calculator button levels, then
//            issues a timed btnd execute press. Optional loopback decoder
//            check: CALC_BTN_ENCODER_LOOPBACK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
//==============================================================================
// Module   : calc_btn_decoder
// Brief    : Button-level to ALU opcode decoder, used as the loopback reference.
// Revision : 1.0 - initial release
//==============================================================================
module calc_btn_decoder (
    input  logic       btnc,
    input  logic       btnl,
    input  logic       btnr,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = 4'b0000;
        case ({btnc, btnl, btnr})
            3'b100:  alu_op = 4'b0000;
            3'b101:  alu_op = 4'b0001;
            3'b000:  alu_op = 4'b0010;
            3'b001:  alu_op = 4'b0110;
            3'b011:  alu_op = 4'b0111;
            3'b110:  alu_op = 4'b1001;
            3'b111:  alu_op = 4'b1010;
            3'b010:  alu_op = 4'b1101;
            default: alu_op = 4'b0000;
        endcase
    end

endmodule
`endif

module calc_btn_encoder #(
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned PRESS_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    output logic       op_err,
    output logic       busy,
    output logic       btnc,
    output logic       btnl,
    output logic       btnr,
    output logic       btnd
`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
    ,
    output logic       chk_err
`endif
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_press = 3'd2;
    localparam logic [2:0] c_st_hold  = 3'd3;
    localparam logic [2:0] c_st_gap   = 3'd4;

    localparam logic [CNT_W-1:0] c_setup_last = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_press_last = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_pat;
    logic [2:0]       r_btn;
    logic             r_btnd;
    logic             r_op_ready;
    logic             r_busy;
    logic             r_op_err;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_enc_pat;
    logic             w_enc_ok;
    logic             w_accept;
    logic             w_load;
    logic             w_last;
    logic             w_drive;
    logic [2:0]       w_pat_nxt;

    // Opcode -> {btnc, btnl, btnr}; unlisted codes are rejected
    always_comb begin
        w_enc_pat = 3'b000;
        w_enc_ok  = 1'b1;
        case (op_code)
            4'b0000: w_enc_pat = 3'b100;
            4'b0001: w_enc_pat = 3'b101;
            4'b0010: w_enc_pat = 3'b000;
            4'b0110: w_enc_pat = 3'b001;
            4'b0111: w_enc_pat = 3'b011;
            4'b1001: w_enc_pat = 3'b110;
            4'b1010: w_enc_pat = 3'b111;
            4'b1101: w_enc_pat = 3'b010;
            default: begin
                w_enc_pat = 3'b000;
                w_enc_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_last      = 1'b0;
        w_accept    = op_valid & r_op_ready;
        w_load      = w_accept & w_enc_ok;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                if (w_load) begin
                    w_state_nxt = c_st_setup;
                end
            end
            c_st_setup: begin
                w_last = (r_cnt == c_setup_last);
                if (w_last) begin
                    w_state_nxt = c_st_press;
                end
            end
            c_st_press: begin
                w_last = (r_cnt == c_press_last);
                if (w_last) begin
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold: begin
                w_last = (r_cnt == c_hold_last);
                if (w_last) begin
                    w_state_nxt = c_st_gap;
                end
            end
            c_st_gap: begin
                w_last = (r_cnt == c_gap_last);
                if (w_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_last) begin
            w_cnt_nxt = '0;
        end
        w_pat_nxt = w_load ? w_enc_pat : r_pat;
        w_drive   = (w_state_nxt == c_st_setup) || (w_state_nxt == c_st_press) ||
                    (w_state_nxt == c_st_hold);
    end

    // Outputs are registered from the next state so they never glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_pat      <= 3'b000;
            r_btn      <= 3'b000;
            r_btnd     <= 1'b0;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_op_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pat      <= w_pat_nxt;
            r_btn      <= w_drive ? w_pat_nxt : 3'b000;
            r_btnd     <= (w_state_nxt == c_st_press);
            r_op_ready <= (w_state_nxt == c_st_idle);
            r_busy     <= (w_state_nxt != c_st_idle);
            r_op_err   <= w_accept & ~w_enc_ok;
        end
    end

    assign op_ready = r_op_ready;
    assign op_err   = r_op_err;
    assign busy     = r_busy;
    assign btnc     = r_btn[2];
    assign btnl     = r_btn[1];
    assign btnr     = r_btn[0];
    assign btnd     = r_btnd;

`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
    logic [3:0] r_op;
    logic [3:0] w_dec_op;
    logic       r_chk_err;

    calc_btn_decoder u_dec (
        .btnc   (r_btn[2]),
        .btnl   (r_btn[1]),
        .btnr   (r_btn[0]),
        .alu_op (w_dec_op)
    );

    // Sticky until reset: the press must decode back to the accepted opcode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= 4'b0000;
            r_chk_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_op <= op_code;
            end
            if ((r_state == c_st_press) && (w_dec_op != r_op)) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_btn_encoder.sv
//==============================================================================
// Module   : tb_calc_btn_encoder
// Brief    : Directed self-checking bench for calc_btn_encoder (default and
//            single-cycle timing instances).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_calc_btn_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid_a, op_valid_b;
    logic [3:0] op_code_a, op_code_b;
    logic       ready_a, err_a, busy_a, c_a, l_a, r_a, d_a;
    logic       ready_b, err_b, busy_b, c_b, l_b, r_b, d_b;
`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
    logic       chk_a, chk_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_btn_encoder u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid_a),
        .op_ready (ready_a),
        .op_code  (op_code_a),
        .op_err   (err_a),
        .busy     (busy_a),
        .btnc     (c_a),
        .btnl     (l_a),
        .btnr     (r_a),
        .btnd     (d_a)
`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
        ,
        .chk_err  (chk_a)
`endif
    );

    calc_btn_encoder #(
        .SETUP_CYCLES (1),
        .PRESS_CYCLES (1),
        .HOLD_CYCLES  (1),
        .GAP_CYCLES   (1)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid_b),
        .op_ready (ready_b),
        .op_code  (op_code_b),
        .op_err   (err_b),
        .busy     (busy_b),
        .btnc     (c_b),
        .btnl     (l_b),
        .btnr     (r_b),
        .btnd     (d_b)
`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
        ,
        .chk_err  (chk_b)
`endif
    );

    // Observed vector: {op_err, op_ready, busy, btnc, btnl, btnr, btnd}
    logic [6:0] w_va, w_vb;
    assign w_va = {err_a, ready_a, busy_a, c_a, l_a, r_a, d_a};
    assign w_vb = {err_b, ready_b, busy_b, c_b, l_b, r_b, d_b};

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %b required %b", tag, obs, exp);
            $error("compare %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at cycle 1 after a valid accept on DUT A with default timing
    task automatic watch_a(input string tag, input logic [2:0] pat, input logic [3:0] mid_code,
                           input logic next_valid, input logic [3:0] next_code);
        logic [6:0] exp;
        for (int k = 1; k <= 19; k++) begin
            exp = {1'b0, (k >= 19), (k <= 18), ((k <= 14) ? pat : 3'b000), (k >= 5 && k <= 12)};
            check($sformatf("%s_k%0d", tag, k), w_va, exp);
            if (k == 6) op_code_a = mid_code;
            if (k == 19) begin
                op_valid_a = next_valid;
                op_code_a  = next_code;
            end
            step();
        end
    endtask

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                             4'b0111, 4'b1001, 4'b1010, 4'b1101};
    logic [2:0] pats  [8] = '{3'b100, 3'b101, 3'b000, 3'b001,
                             3'b011, 3'b110, 3'b111, 3'b010};

    initial begin
        reset = 1'b1;
        op_valid_a = 1'b0; op_code_a = 4'b0000;
        op_valid_b = 1'b0; op_code_b = 4'b0000;
        #1;
        check("reset_a", w_va, 7'b0100000);
        check("reset_b", w_vb, 7'b0100000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("idle_a", w_va, 7'b0100000);

        // Single request 0110 -> 001
        op_valid_a = 1'b1; op_code_a = 4'b0110;
        step();
        op_valid_a = 1'b0;
        watch_a("single", 3'b001, 4'b0110, 1'b0, 4'b0000);

        // All valid codes back-to-back with op_valid held high
        op_valid_a = 1'b1; op_code_a = codes[0];
        step();
        for (int i = 0; i < 8; i++) begin
            watch_a($sformatf("b2b%0d", i), pats[i], 4'b1111,
                    (i < 7), (i < 7) ? codes[(i + 1) % 8] : 4'b0000);
        end

        // Invalid codes: one-cycle op_err, nothing else moves
        op_valid_a = 1'b1; op_code_a = 4'b0011;
        step();
        check("inv0011_err", w_va, 7'b1100000);
        op_valid_a = 1'b0;
        step();
        check("inv0011_after", w_va, 7'b0100000);
        op_valid_a = 1'b1; op_code_a = 4'b1111;
        step();
        check("inv1111_err", w_va, 7'b1100000);
        op_valid_a = 1'b0;
        step();
        check("inv1111_after", w_va, 7'b0100000);

        // op_code changes during PRESS are ignored
        op_valid_a = 1'b1; op_code_a = 4'b1101;
        step();
        op_valid_a = 1'b0;
        watch_a("late_chg", 3'b010, 4'b0000, 1'b0, 4'b0000);

        // Reset asserted mid-PRESS
        op_valid_a = 1'b1; op_code_a = 4'b0111;
        step();
        op_valid_a = 1'b0;
        repeat (6) step();
        check("pre_reset_press", w_va, 7'b0010111);
        reset = 1'b1;
        #1;
        check("async_reset", w_va, 7'b0100000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_release", w_va, 7'b0100000);
        step();
        check("no_resume", w_va, 7'b0100000);
        op_valid_a = 1'b1; op_code_a = 4'b1010;
        step();
        op_valid_a = 1'b0;
        watch_a("post_reset", 3'b111, 4'b1010, 1'b0, 4'b0000);

        // Single-cycle timing instance, 0001 -> 101
        op_valid_b = 1'b1; op_code_b = 4'b0001;
        step();
        op_valid_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("fast_k%0d", k), w_vb,
                  {1'b0, (k >= 5), (k <= 4), ((k <= 3) ? 3'b101 : 3'b000), (k == 2)});
            if (k < 5) step();
        end

`ifdef CALC_BTN_ENCODER_LOOPBACK_EN
        check("chk_err_a", {6'b000000, chk_a}, 7'b0000000);
        check("chk_err_b", {6'b000000, chk_b}, 7'b0000000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_btn_encoder.md
Name: calc_btn_encoder

Overview:
- Inverse of the calculator's button-to-opcode decoder. It accepts a 4-bit ALU opcode over a valid/ready handshake and encodes it into the btnc/btnl/btnr level pattern that decodes back to that opcode.
- It then emits a timed btnd "execute" press, so the calculator datapath sees the same stimulus as a human press.
- Used by the demo/self-test sequencer to drive the calculator without physical buttons.

Parameters:
- SETUP_CYCLES, 4: cycles btnc/btnl/btnr are stable before btnd rises (min 1).
- PRESS_CYCLES, 8: cycles btnd is held high (min 1).
- HOLD_CYCLES, 2: cycles btnc/btnl/btnr stay stable after btnd falls (min 1).
- GAP_CYCLES, 4: idle cycles with all buttons low before op_ready reasserts (min 1).
- CNT_W, 16: width of the phase counter. Every *_CYCLES value must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op_valid  input  1  request valid
- op_ready  output  1  encoder can accept a request
- op_code  input  4  requested alu_op
- op_err  output  1  one-cycle pulse: op_code not encodable
- busy  output  1  high from accept through end of GAP
- btnc  output  1  centre button level
- btnl  output  1  left button level
- btnr  output  1  right button level
- btnd  output  1  execute button level

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values: all outputs 0 except op_ready=1. The FSM goes to IDLE and the counter clears.
- Encoding table, op_code -> {btnc,btnl,btnr}:
  - 0000 -> 100
  - 0001 -> 101
  - 0010 -> 000
  - 0110 -> 001
  - 0111 -> 011
  - 1001 -> 110
  - 1010 -> 111
  - 1101 -> 010
  - All other 8 codes are invalid.
- Handshake: a request is accepted on a rising edge where op_valid & op_ready. op_ready is high only in IDLE.
  - op_code is sampled once at accept and registered. Later changes to op_code are ignored.
  - Invalid code: op_err pulses for exactly 1 cycle (the cycle after accept). The FSM stays in IDLE, no buttons move, op_ready stays 1, busy stays 0.
  - Valid code: the encoded pattern is registered onto btnc/btnl/btnr in the cycle after accept. Outputs are registered and never glitch.
- FSM states: IDLE, SETUP, PRESS, HOLD, GAP.
  - IDLE: buttons 0. Valid accept -> SETUP.
  - SETUP: pattern driven, btnd=0, for SETUP_CYCLES cycles -> PRESS.
  - PRESS: pattern driven, btnd=1, for PRESS_CYCLES cycles -> HOLD.
  - HOLD: pattern driven, btnd=0, for HOLD_CYCLES cycles -> GAP.
  - GAP: all buttons 0 for GAP_CYCLES cycles -> IDLE.
- Counter: loads 0 on each state entry and advances when count == N-1.
- Latency: accept to first btnd=1 cycle is SETUP_CYCLES+1. Accept to op_ready high is SETUP+PRESS+HOLD+GAP+1 cycles.
- Back-to-back: op_valid held high across GAP is accepted on the first IDLE cycle. No extra bubble.
- Reset mid-sequence: all buttons drop to 0 immediately (async) and the FSM goes to IDLE. No partial btnd pulse may resume after reset deasserts.
- btnd never rises unless btnc/btnl/btnr have been stable for ≥ SETUP_CYCLES. The pattern never changes while btnd=1.

Optional Feature:
- Macro: CALC_BTN_ENCODER_LOOPBACK_EN.
- With the macro defined:
  - The block instantiates the existing decoder module on its own btnc/btnl/btnr outputs.
  - It adds output port chk_err (1 bit, reset 0). chk_err is set sticky when, in PRESS, the decoder alu_op differs from the registered op_code. Only reset clears it.
- Without the macro: no decoder instance and no chk_err port. The rest of the behaviour is identical.

Test Plan:
- Defaults. Send op_code=0110 -> 1 cycle later {c,l,r}=001. btnd high for 8 cycles starting 5 cycles after accept. Buttons all 0 after cycle 15. op_ready high again at cycle 19 after accept.
- Send each of the 8 valid codes back-to-back with op_valid held -> patterns match the table and each btnd pulse is exactly 8 cycles. With LOOPBACK_EN, chk_err stays 0.
- Send op_code=0011, then 1111 -> op_err pulses 1 cycle each, btn* stay 0, op_ready never drops.
- Send op_code=1101, change op_code to 0000 during PRESS -> outputs stay 010 until GAP.
- Assert reset in PRESS for 1 cycle -> btnd and btn* go to 0 asynchronously, op_ready=1. The next request 1010 produces 111 and a full 8-cycle btnd pulse.
- Set SETUP=PRESS=HOLD=GAP=1, send 0001 -> btnd high for exactly 1 cycle at accept+2. op_ready returns at accept+5.
